// File: rtl/avalon_msg_arbiter.sv
// Message-level round-robin arbiter: merges NUM_LANES Avalon-ST sources onto
// one Avalon-ST sink. A lane is locked from its sop beat to its eop beat, so
// beats of different messages never interleave on the output.
// Optional feature macro: DROP_ORPHAN_EN -- while idle, beats presented
// without sop are accepted and discarded, reported on orphan_drop_indi.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no lane owns the output; arbitrate among lanes presenting sop
// ST_LOCKED | lane grant_lane is muxed onto the output until its eop beat
module avalon_msg_arbiter #(
  parameter int NUM_LANES           = 4,
  parameter int DATA_WIDTH_IN_BYTES = 8,
  parameter int STALL_TIMEOUT       = 255,
  localparam int DBW = DATA_WIDTH_IN_BYTES * 8,
  localparam int EW  = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1,
  localparam int LW  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_LANES*DBW-1:0] in_data,
  input  logic [NUM_LANES-1:0]     in_valid,
  input  logic [NUM_LANES-1:0]     in_sop,
  input  logic [NUM_LANES-1:0]     in_eop,
  input  logic [NUM_LANES*EW-1:0]  in_empty,
  output logic [NUM_LANES-1:0]     in_rdy,
  output logic [DBW-1:0]           out_data,
  output logic                     out_valid,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [EW-1:0]            out_empty,
  input  logic                     out_rdy,
  output logic [LW-1:0]            grant_lane,
  output logic                     busy,
`ifdef DROP_ORPHAN_EN
  output logic                     orphan_drop_indi,
`endif
  output logic                     stall_indi
);

  localparam int CW = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
  // Counter value at which the next idle cycle completes the timeout window.
  localparam logic [CW-1:0] TO_LAST = (STALL_TIMEOUT > 0) ? CW'(STALL_TIMEOUT - 1) : '0;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t          r_state;
  logic [LW-1:0]   r_rr_ptr;
  logic [LW-1:0]   r_grant;
  logic            r_busy;
  logic            r_stall;
  logic [CW-1:0]   r_idle_cnt;

  logic [NUM_LANES-1:0] w_req;
  logic                 w_any_req;
  logic [LW-1:0]        w_winner;
  logic [LW:0]          w_cand;
  logic                 w_locked;
  logic                 w_beat;
  logic [DBW-1:0]       w_lane_data;
  logic                 w_lane_valid;
  logic                 w_lane_sop;
  logic                 w_lane_eop;
  logic [EW-1:0]        w_lane_empty;

  assign w_req    = in_valid & in_sop;
  assign w_locked = (r_state == ST_LOCKED);

  // Round-robin search starting just after the last served lane; scanning from
  // the far end lets the nearest requesting lane overwrite earlier candidates.
  always_comb begin
    w_any_req = 1'b0;
    w_winner  = '0;
    w_cand    = '0;
    for (int k = NUM_LANES; k >= 1; k--) begin
      w_cand = {1'b0, r_rr_ptr} + (LW+1)'(k);
      if (w_cand >= (LW+1)'(NUM_LANES)) begin
        w_cand = w_cand - (LW+1)'(NUM_LANES);
      end
      if (w_req[w_cand[LW-1:0]]) begin
        w_any_req = 1'b1;
        w_winner  = w_cand[LW-1:0];
      end
    end
  end

  // Select the granted lane's inputs.
  always_comb begin
    w_lane_data  = '0;
    w_lane_valid = 1'b0;
    w_lane_sop   = 1'b0;
    w_lane_eop   = 1'b0;
    w_lane_empty = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (r_grant == LW'(i)) begin
        w_lane_data  = in_data[i*DBW +: DBW];
        w_lane_valid = in_valid[i];
        w_lane_sop   = in_sop[i];
        w_lane_eop   = in_eop[i];
        w_lane_empty = in_empty[i*EW +: EW];
      end
    end
  end

  assign out_data  = w_lane_data;
  assign out_valid = w_locked & w_lane_valid;
  assign out_sop   = w_locked & w_lane_sop;
  assign out_eop   = w_locked & w_lane_eop;
  assign out_empty = out_eop ? w_lane_empty : '0;
  assign w_beat    = out_valid & out_rdy;

`ifdef DROP_ORPHAN_EN
  logic [NUM_LANES-1:0] w_orphan;
  logic                 r_orphan_drop;

  assign w_orphan = in_valid & ~in_sop;
`endif

  // Backpressure routing: only the locked lane sees the sink ready.
  always_comb begin
    in_rdy = '0;
    if (w_locked) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (r_grant == LW'(i)) begin
          in_rdy[i] = out_rdy;
        end
      end
    end
`ifdef DROP_ORPHAN_EN
    else begin
      in_rdy = w_orphan;
    end
`endif
  end

  // Arbitration FSM with message lock and idle-lane watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= LW'(NUM_LANES - 1);
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_stall    <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      r_stall <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_idle_cnt <= '0;
          if (w_any_req) begin
            r_grant <= w_winner;
            r_busy  <= 1'b1;
            r_state <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_beat) begin
            r_idle_cnt <= '0;
            if (out_eop) begin
              r_rr_ptr <= r_grant;
              r_busy   <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end else if (!w_lane_valid && (STALL_TIMEOUT > 0)) begin
            // Report and restart the window; the message stays locked.
            if (r_idle_cnt >= TO_LAST) begin
              r_stall    <= 1'b1;
              r_idle_cnt <= '0;
            end else begin
              r_idle_cnt <= r_idle_cnt + CW'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DROP_ORPHAN_EN
  // One pulse for every idle cycle that discarded at least one orphan beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_orphan_drop <= 1'b0;
    end else begin
      r_orphan_drop <= (r_state == ST_IDLE) && (|w_orphan);
    end
  end

  assign orphan_drop_indi = r_orphan_drop;
`endif

  assign grant_lane = r_grant;
  assign busy       = r_busy;
  assign stall_indi = r_stall;

endmodule
